// File: rtl/decode_stage.sv
// decode_stage: IF/ID stage behind the instruction fetch memory.
// Captures fetched words, flushes wrong-path words after a taken branch,
// absorbs downstream stalls in a small FIFO skid buffer, and presents
// registered decode fields plus sticky halt/overflow flags.
// Optional build macro: DECODE_PERF_CNT_EN adds bubble/flush counters.
module decode_stage #(
    parameter int unsigned SKID_DEPTH  = 2,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter logic [4:0]  HALT_OPC    = 5'b01011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        fetch_done_i,
    input  logic        branch_taken_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [4:0]  opcode_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [31:0] imm_o,
    output logic        halted_o,
    output logic        overflow_o
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int unsigned FC_W  = $clog2(FLUSH_DEPTH + 2);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Sign-extend the 17-bit immediate field to 32 bits.
    function automatic logic signed [31:0] sext_imm(input logic signed [16:0] imm);
        return 32'(imm);
    endfunction

    // Advance a skid-buffer pointer, wrapping at SKID_DEPTH.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;

    logic [31:0]       skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;

    logic [31:0]       instr_p1;
    logic              vld_p1;
    logic              halted_q;
    logic              overflow_q;

    logic              branch_act;
    logic              accept;
    logic              buf_empty;
    logic              buf_full;
    logic              pop;
    logic              push;
    logic              drop;
    logic              load_direct;

    // A branch is honoured everywhere except after halt; a word carrying the
    // halt opcode is never treated as a live instruction.
    assign branch_act  = branch_taken_i && (state_q != ST_HALT);
    assign accept      = (state_q == ST_RUN) && !fetch_done_i && !branch_taken_i
                         && (instr_i[31:27] != HALT_OPC);
    assign buf_empty   = (occ_q == '0);
    assign buf_full    = (occ_q == OCC_W'(SKID_DEPTH));
    assign pop         = !branch_act && !stall_i && !buf_empty;
    assign load_direct = accept && !stall_i && buf_empty;
    assign push        = accept && (stall_i || !buf_empty) && (!buf_full || pop);
    assign drop        = accept && stall_i && buf_full;

    // FSM state and flush countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FLUSH;
            fcnt_q  <= FC_W'(1);
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state logic: branch wins over halt; FLUSH counts down wrong-path words.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN: begin
                if (branch_taken_i) begin
                    state_d = (FLUSH_DEPTH == 0) ? ST_RUN : ST_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_DEPTH);
                end else if (fetch_done_i) begin
                    state_d = ST_HALT;
                end
            end
            ST_FLUSH: begin
                if (branch_taken_i) begin
                    state_d = (FLUSH_DEPTH == 0) ? ST_RUN : ST_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_DEPTH);
                end else if (fcnt_q <= FC_W'(1)) begin
                    state_d = ST_RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d  = fcnt_q - 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FLUSH;
                fcnt_d  = FC_W'(1);
            end
        endcase
    end

    // Skid buffer storage; occupancy alone marks which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            skid_mem[wr_ptr_q] <= instr_i;
        end
    end

    // Skid buffer pointers and occupancy; a branch empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (branch_act) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                occ_q <= occ_q + 1'b1;
            end else if (pop && !push) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

    // Output stage: buffered words drain first, else accepted input goes straight through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (branch_act) begin
            vld_p1   <= 1'b0;
        end else if (!stall_i) begin
            if (pop) begin
                instr_p1 <= skid_mem[rd_ptr_q];
                vld_p1   <= 1'b1;
            end else if (load_direct) begin
                instr_p1 <= instr_i;
                vld_p1   <= 1'b1;
            end else begin
                vld_p1   <= 1'b0;
            end
        end
    end

    // Sticky status: halt once everything ahead of it has issued; overflow on a dropped word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if ((state_q == ST_HALT) && buf_empty && !stall_i) begin
                halted_q <= 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign valid_o    = vld_p1;
    assign opcode_o   = instr_p1[31:27];
    assign rd_o       = instr_p1[26:22];
    assign rs1_o      = instr_p1[21:17];
    assign rs2_o      = instr_p1[16:12];
    assign imm_o      = sext_imm(instr_p1[16:0]);
    assign halted_o   = halted_q;
    assign overflow_o = overflow_q;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;

    // Performance counters: idle output cycles before halt, and honoured branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (!vld_p1 && (state_q != ST_HALT)) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
            if (branch_act) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: scenario tasks drive the fetch stream and push
// the words they expect to see issued; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_decode_stage;

    localparam int SKID = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i;
    logic        fetch_done_i;
    logic        branch_taken_i;
    logic        stall_i;
    logic        valid_o;
    logic [4:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [31:0] imm_o;
    logic        halted_o;
    logic        overflow_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic        mon_stall;
    logic [31:0] mon_w;

    decode_stage #(.SKID_DEPTH(SKID), .FLUSH_DEPTH(1), .HALT_OPC(5'b01011)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_i       (instr_i),
        .fetch_done_i  (fetch_done_i),
        .branch_taken_i(branch_taken_i),
        .stall_i       (stall_i),
        .valid_o       (valid_o),
        .opcode_o      (opcode_o),
        .rd_o          (rd_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .imm_o         (imm_o),
        .halted_o      (halted_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [51:0] model_fields(input logic [31:0] w);
        logic [31:0] imm;
        imm = w[16] ? {15'h7fff, w[16:0]} : {15'h0000, w[16:0]};
        return {w[31:27], w[26:22], w[21:17], w[16:12], imm};
    endfunction

    // Monitor: every edge taken without stall that leaves valid_o high issues one word.
    always @(posedge clk) begin
        mon_stall = stall_i;
        #0.5;
        if (valid_o === 1'b1 && mon_stall === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected got op=%0d rd=%0d imm=%h required no issue",
                         opcode_o, rd_o, imm_o);
            end else begin
                mon_w = exp_q.pop_front();
                if ({opcode_o, rd_o, rs1_o, rs2_o, imm_o} !== model_fields(mon_w)) begin
                    errors++;
                    $display("FAIL issue_fields got %h required %h (word %h)",
                             {opcode_o, rd_o, rs1_o, rs2_o, imm_o}, model_fields(mon_w), mon_w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] w, input logic st, input bit expect_issue);
        instr_i = w;
        stall_i = st;
        if (expect_issue) exp_q.push_back(w);
        tick();
    endtask

    // Reset, release, and burn the post-reset flush word so the stage sits in RUN.
    task automatic sync_reset();
        rst_n = 1'b0;
        stall_i = 1'b0;
        branch_taken_i = 1'b0;
        fetch_done_i = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        drive(32'h7777_7777, 1'b0, 1'b0);
    endtask

    // Stop fetch so the buffer drains, then confirm every expected word issued.
    task automatic drain(input string name);
        fetch_done_i = 1'b1;
        stall_i = 1'b0;
        instr_i = 32'h5800_0000;
        repeat (SKID + 2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got %0d words left required 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (halted_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_halted got %b required 1", name, halted_o);
        end
        fetch_done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_i = 32'h0;
        stall_i = 1'b0;
        branch_taken_i = 1'b0;
        fetch_done_i = 1'b0;
        tick();
        tick();
        checks++;
        if ({valid_o, opcode_o, rd_o, rs1_o, rs2_o, imm_o, halted_o, overflow_o} !== 55'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0",
                     {valid_o, opcode_o, rd_o, rs1_o, rs2_o, imm_o, halted_o, overflow_o});
        end
    endtask

    task automatic test_first_word();
        rst_n = 1'b1;
        drive(32'h0840_0000, 1'b0, 1'b0);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL first_discard valid_o got %b required 0", valid_o);
        end
        drive(32'h1000_0000, 1'b0, 1'b1);
        checks++;
        if (valid_o !== 1'b1 || opcode_o !== 5'd2) begin
            errors++;
            $display("FAIL first_issue got valid=%b op=%0d required valid=1 op=2", valid_o, opcode_o);
        end
        drain("first");
    endtask

    task automatic test_skid_overflow();
        sync_reset();
        drive(32'h1111_1111, 1'b0, 1'b1);
        drive(32'h2222_2222, 1'b1, 1'b1);
        drive(32'h3333_3333, 1'b1, 1'b1);
        checks++;
        if (overflow_o !== 1'b0 || opcode_o !== 5'd2) begin
            errors++;
            $display("FAIL skid_hold got ovf=%b op=%0d required ovf=0 op=2", overflow_o, opcode_o);
        end
        drive(32'h4444_4444, 1'b1, 1'b0);
        checks++;
        if (overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL skid_overflow got %b required 1", overflow_o);
        end
        drive(32'h6666_6666, 1'b0, 1'b1);
        drive(32'h8888_8888, 1'b0, 1'b1);
        drain("skid");
        checks++;
        if (overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL skid_overflow_sticky got %b required 1", overflow_o);
        end
    endtask

    task automatic test_branch_flush();
        sync_reset();
        drive(32'h1111_1111, 1'b0, 1'b1);
        drive(32'h2222_2222, 1'b1, 1'b0);
        drive(32'h3333_3333, 1'b1, 1'b0);
        branch_taken_i = 1'b1;
        drive(32'h4444_4444, 1'b1, 1'b0);
        branch_taken_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL branch_kill valid_o got %b required 0", valid_o);
        end
        drive(32'h6666_6666, 1'b0, 1'b0);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL branch_flush valid_o got %b required 0", valid_o);
        end
        drive(32'h8888_8888, 1'b0, 1'b1);
        checks++;
        if (valid_o !== 1'b1 || opcode_o !== 5'd17) begin
            errors++;
            $display("FAIL branch_resume got valid=%b op=%0d required valid=1 op=17", valid_o, opcode_o);
        end
        drain("branch");
    endtask

    task automatic test_imm_back_to_back();
        sync_reset();
        drive(32'h0001_FFFF, 1'b0, 1'b1);
        checks++;
        if (imm_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL imm_negative got %h required ffffffff", imm_o);
        end
        drive(32'h0000_FFFF, 1'b0, 1'b1);
        checks++;
        if (imm_o !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL imm_positive got %h required 0000ffff", imm_o);
        end
        drive(32'h9999_9999, 1'b0, 1'b1);
        drain("imm");
    endtask

    task automatic test_halt();
        sync_reset();
        drive(32'h1111_1111, 1'b0, 1'b1);
        drive(32'h2222_2222, 1'b1, 1'b1);
        fetch_done_i = 1'b1;
        drive(32'h5800_0000, 1'b1, 1'b0);
        checks++;
        if (halted_o !== 1'b0) begin
            errors++;
            $display("FAIL halt_early got %b required 0", halted_o);
        end
        drive(32'h5800_0000, 1'b0, 1'b0);
        checks++;
        if (valid_o !== 1'b1 || halted_o !== 1'b0 || opcode_o !== 5'd4) begin
            errors++;
            $display("FAIL halt_drain got valid=%b halted=%b op=%0d required 1 0 4",
                     valid_o, halted_o, opcode_o);
        end
        drive(32'h5800_0000, 1'b0, 1'b0);
        checks++;
        if (valid_o !== 1'b0 || halted_o !== 1'b1) begin
            errors++;
            $display("FAIL halt_set got valid=%b halted=%b required 0 1", valid_o, halted_o);
        end
        branch_taken_i = 1'b1;
        drive(32'h5800_0000, 1'b0, 1'b0);
        branch_taken_i = 1'b0;
        fetch_done_i = 1'b0;
        drive(32'h3333_3333, 1'b0, 1'b0);
        drive(32'h4444_4444, 1'b0, 1'b0);
        checks++;
        if (valid_o !== 1'b0 || halted_o !== 1'b1) begin
            errors++;
            $display("FAIL halt_terminal got valid=%b halted=%b required 0 1", valid_o, halted_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL halt_pending got %0d words left required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_async_reset();
        sync_reset();
        drive(32'h1111_1111, 1'b0, 1'b1);
        drive(32'h2222_2222, 1'b1, 1'b0);
        drive(32'h3333_3333, 1'b1, 1'b0);
        drive(32'h4444_4444, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid_o, opcode_o, rd_o, rs1_o, rs2_o, imm_o, halted_o, overflow_o} !== 55'd0) begin
            errors++;
            $display("FAIL async_reset got %h required 0",
                     {valid_o, opcode_o, rd_o, rs1_o, rs2_o, imm_o, halted_o, overflow_o});
        end
        stall_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        drive(32'h6666_6666, 1'b0, 1'b0);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL async_discard valid_o got %b required 0", valid_o);
        end
        drive(32'h8888_8888, 1'b0, 1'b1);
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL async_issue valid_o got %b required 1", valid_o);
        end
        drain("async");
    endtask

    initial begin
        rst_n = 1'b0;
        instr_i = 32'h0;
        stall_i = 1'b0;
        branch_taken_i = 1'b0;
        fetch_done_i = 1'b0;
        test_reset();
        test_first_word();
        test_skid_overflow();
        test_branch_flush();
        test_imm_back_to_back();
        test_halt();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

endmodule
